pc_stack: RTL

Parametrised program-counter unit: the next generation of the fetch-stage PC generator. Adds configurable PC and immediate widths, full sign-extended branch and jump offsets, a circular return-address stack (RAS) that checks JAL/JR pairing, and a counter of taken redirects. It sits at the head of the fetch stage. It drives the instruction-memory address and the REG1 flush, and takes decode-stage opcode fields and the register-file rb read.

---
 rtl/pc_stack_pkg.sv | 30 +++
 rtl/pc_ras.sv | 77 +++++++
 rtl/pc_stack.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pc_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_pkg
// Description : Shared decode constants for the fetch-stage PC generator.
//               Holds the opcode and sub-op encodings and the PC select codes.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package pc_stack_pkg;

  // Decode-stage opcodes that redirect the fetch stream
  localparam logic [5:0] TY_B = 6'h04;  // conditional branch
  localparam logic [5:0] TY_J = 6'h02;  // unconditional jump / jump-and-link
  localparam logic [5:0] JR   = 6'h08;  // jump to register

  // Sub-op selects
  localparam logic BEQ = 1'b0;
  localparam logic BNE = 1'b1;
  localparam logic JAL = 1'b1;          // sub_op_j == 0 is a plain J

  // Next-PC source; the names keep their historical immediate widths even
  // though the immediate widths are now parameters.
  typedef enum logic [1:0] {
    PC_4        = 2'd0,
    PC_14BIT    = 2'd1,
    PC_24BIT    = 2'd2,
    PC_REGISTER = 2'd3
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. A push when full overwrites
//               the oldest entry; a pop when empty is ignored. Both raise a
//               sticky flag. State changes on the falling clock edge.
// Ports       : clock, reset      - clock / synchronous active-high reset
//               push, pop         - stack operations (mutually exclusive)
//               push_data         - address to push
//               top               - most recently pushed entry
//               count             - number of valid entries (0..RAS_DEPTH)
//               overflow          - sticky: push while full
//               underflow         - sticky: pop while empty
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_WIDTH  = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_WIDTH-1:0]          push_data,
  output logic [PC_WIDTH-1:0]          top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr;      // next free slot; wraps modulo RAS_DEPTH
  logic [PTR_W-1:0]    top_idx;
  logic                full;
  logic                empty;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign full    = (count == (PTR_W+1)'(RAS_DEPTH));
  assign empty   = (count == '0);

  // Storage has no reset; contents are only meaningful below count.
  // When full, ptr already addresses the oldest entry, so a push there
  // naturally overwrites it.
  always_ff @(negedge clock) begin
    if (!reset && push) begin
      mem[ptr] <= push_data;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + (PTR_W+1)'(1);
      end
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= top_idx;
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Fetch-stage program counter with sign-extended branch/jump
//               targets, a return-address stack that checks JAL/JR pairing,
//               and a saturating count of taken redirects. All state changes
//               on the falling clock edge.
// Ports       : clock, reset           - clock / synchronous active-high reset
//               enable_pc, do_hazard   - advance permit / stall
//               opcode, sub_op_b/j     - decode-stage instruction fields
//               reg_rt_ra_equal        - branch compare result
//               imm_b, imm_j           - branch / jump immediates
//               reg_rb_data            - JR target register
//               current_pc             - instruction fetch address
//               do_jump_link           - JAL in decode
//               do_flush_REG1          - redirect selected
//               ras_mismatch           - JR target differs from RAS top
//               ras_count, ras_overflow, ras_underflow - RAS status
//               redirect_count         - taken redirects since reset
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int               PC_WIDTH    = 10,
  parameter int               IMM_B_WIDTH = 14,
  parameter int               IMM_J_WIDTH = 24,
  parameter int               RAS_DEPTH   = 4,
  parameter int               CNT_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable_pc,
  input  logic                        do_hazard,
  input  logic [5:0]                  opcode,
  input  logic                        sub_op_b,
  input  logic                        sub_op_j,
  input  logic                        reg_rt_ra_equal,
  input  logic [IMM_B_WIDTH-1:0]      imm_b,
  input  logic [IMM_J_WIDTH-1:0]      imm_j,
  input  logic [31:0]                 reg_rb_data,
  output logic [PC_WIDTH-1:0]         current_pc,
  output logic                        do_jump_link,
  output logic                        do_flush_REG1,
  output logic                        ras_mismatch,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow,
  output logic [CNT_WIDTH-1:0]        redirect_count
);

  pc_sel_e             sel;
  logic                adv;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] pc_base;
  logic [PC_WIDTH-1:0] b_off;
  logic [PC_WIDTH-1:0] j_off;
  logic [PC_WIDTH-1:0] rb_target;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push;
  logic                ras_pop;

  assign adv       = enable_pc & ~do_hazard;
  assign rb_target = reg_rb_data[PC_WIDTH-1:0];

  // Only the low PC_WIDTH bits of the register form an address.
  if (PC_WIDTH < 32) begin : g_rb_unused
    logic unused_rb_hi;
    assign unused_rb_hi = ^reg_rb_data[31:PC_WIDTH];
  end

  // Target select
  always_comb begin
    sel = PC_4;
    unique case (opcode)
      TY_B: begin
        if ((sub_op_b == BEQ &&  reg_rt_ra_equal) ||
            (sub_op_b == BNE && !reg_rt_ra_equal)) begin
          sel = PC_14BIT;
        end
      end
      TY_J:    sel = PC_24BIT;
      JR:      sel = PC_REGISTER;
      default: sel = PC_4;
    endcase
  end

  assign do_jump_link  = (opcode == TY_J) && (sub_op_j == JAL);
  assign do_flush_REG1 = (sel != PC_4);

  // Relative targets are taken from the PC of the instruction in decode,
  // which is one word behind the fetch address. The size cast sign-extends
  // the doubled immediate to PC_WIDTH, or truncates it when it is wider.
  assign pc_base = current_pc - PC_WIDTH'(4);
  assign b_off   = PC_WIDTH'($signed({imm_b, 1'b0}));
  assign j_off   = PC_WIDTH'($signed({imm_j, 1'b0}));

  always_comb begin
    next_pc = current_pc + PC_WIDTH'(4);
    unique case (sel)
      PC_14BIT:    next_pc = pc_base + b_off;
      PC_24BIT:    next_pc = pc_base + j_off;
      PC_REGISTER: next_pc = rb_target;
      default:     next_pc = current_pc + PC_WIDTH'(4);
    endcase
  end

  // The link address pushed is the fetch address at the time of the JAL.
  assign ras_push = adv && (sel == PC_24BIT) && do_jump_link;
  assign ras_pop  = adv && (sel == PC_REGISTER);

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (current_pc),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign ras_mismatch = (opcode == JR) && (ras_count != '0) && (ras_top != rb_target);

  always_ff @(negedge clock) begin
    if (reset) begin
      current_pc     <= RESET_PC;
      redirect_count <= '0;
    end else if (adv) begin
      current_pc <= next_pc;
      if (do_flush_REG1 && (redirect_count != '1)) begin
        redirect_count <= redirect_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire
